// File: rtl/bcd_pkg.sv
// +----------------------------------------------------------------------+
// | bcd_pkg : shared BCD digit type, limits and load sanitising helper    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Out-of-range nibbles collapse to zero so a digit can never leave 0..9.
  function automatic bcd_t bcd_sanitize(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MIN : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// +----------------------------------------------------------------------+
// | bcd_digit : one decade cell, up/down with carry/borrow out and load   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic step_in,
  input  logic up,
  input  logic load,
  input  bcd_t load_digit,
  output bcd_t digit,
  output logic step_out
);

  bcd_t r_digit;
  bcd_t w_next;

  always_comb begin
    w_next = r_digit;
    if (load) begin
      w_next = bcd_sanitize(load_digit);
    end else if (step_in) begin
      if (up) begin
        w_next = (r_digit >= BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
      end else begin
        w_next = (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit <= BCD_MIN;
    end else begin
      r_digit <= w_next;
    end
  end

  // Carry (up) or borrow (down) ripples to the next decade on the same step.
  assign step_out = step_in & ~load &
                    (up ? (r_digit >= BCD_MAX) : (r_digit == BCD_MIN));
  assign digit    = r_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_counter2.sv
// +----------------------------------------------------------------------+
// | bcd_counter2 : two-digit BCD up/down counter with prescaler, load,    |
// |                registered tick and wrap pulses                        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_counter2
  import bcd_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       tick,
  output logic       wrap
);

  localparam int            PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic          r_tick;
  logic          r_wrap;
  logic          w_step;
  logic          w_count;
  logic          w_units_carry;
  logic          w_tens_carry;
  bcd_t          w_units;
  bcd_t          w_tens;

  assign w_step  = en & (r_pcnt == PMAX);
  // Load pre-empts any step that happens to land on the same cycle.
  assign w_count = w_step & ~load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= '0;
    end else if (load) begin
      r_pcnt <= '0;
    end else if (en) begin
      r_pcnt <= w_step ? '0 : r_pcnt + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= w_count;
      r_wrap <= w_tens_carry;
    end
  end

  bcd_digit u_units (
    .clk        (clk),
    .reset      (reset),
    .step_in    (w_count),
    .up         (up),
    .load       (load),
    .load_digit (load_val[3:0]),
    .digit      (w_units),
    .step_out   (w_units_carry)
  );

  bcd_digit u_tens (
    .clk        (clk),
    .reset      (reset),
    .step_in    (w_units_carry),
    .up         (up),
    .load       (load),
    .load_digit (load_val[7:4]),
    .digit      (w_tens),
    .step_out   (w_tens_carry)
  );

  assign digit0 = w_units;
  assign digit1 = w_tens;
  assign tick   = r_tick;
  assign wrap   = r_wrap;

endmodule

`default_nettype wire

// File: doc/bcd_counter2.md
BCD_COUNTER2 -- requirements
Module: bcd_counter2

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, meaning clk cycles per count step (1 Hz at 50 MHz); legal values are 2 or greater.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit, count enable; it gates both the prescaler and the digit update.
REQ-005 The block SHALL have port up, input, 1 bit, direction: 1 = increment, 0 = decrement.
REQ-006 The block SHALL have port load, input, 1 bit, a synchronous load strobe.
REQ-007 The block SHALL have port load_val, input, 8 bits: [7:4] is the tens BCD digit and [3:0] is the units BCD digit.
REQ-008 The block SHALL have port digit0, output, 4 bits, units BCD digit (0..9), intended to drive the existing 7-seg decoder for HEX0.
REQ-009 The block SHALL have port digit1, output, 4 bits, tens BCD digit (0..9), intended to drive the existing 7-seg decoder for HEX1.
REQ-010 The block SHALL have port tick, output, 1 bit, a registered one-cycle pulse marking each count step.
REQ-011 The block SHALL have port wrap, output, 1 bit, a registered one-cycle pulse on a 99->00 or 00->99 transition.

Function
REQ-012 Prescaler: the prescaler SHALL be a counter pcnt, 0..TICK_DIV-1, that increments each cycle while en=1 and holds its value while en=0.
REQ-013 The step condition is pcnt==TICK_DIV-1 with en=1; on that cycle pcnt SHALL return to 0 and a count step SHALL be taken.
REQ-014 tick SHALL be high for exactly the one cycle following each count step; the digits update on that same edge, so latency is 1 clk.
REQ-015 Up step: units 0..8 SHALL increment by 1, and units 9 SHALL go to 0 with a carry into tens.
REQ-016 Up step: tens SHALL increment only on a carry from units, and tens 9 with a carry SHALL go to 0.
REQ-017 Down step: units 1..9 SHALL decrement by 1, and units 0 SHALL go to 9 with a borrow from tens.
REQ-018 Down step: tens 0 with a borrow SHALL go to 9.
REQ-019 wrap SHALL pulse for one cycle, coincident with tick, only when the step is 99->00 (up) or 00->99 (down).
REQ-020 Load: load=1 SHALL take priority over counting; on the next edge the digits take load_val and pcnt clears to 0.
REQ-021 On a load cycle tick and wrap SHALL be 0, even if a count step coincides.
REQ-022 Load of an invalid digit: any load_val nibble greater than 9 SHALL load as 0 in that digit only; the other nibble loads normally.
REQ-023 A change of up between steps SHALL take effect at the next step only; there is no other effect.
REQ-024 en=0 SHALL freeze the digits and pcnt; tick and wrap SHALL be 0 while en=0.
REQ-025 The digits SHALL never hold a value greater than 9 in any reachable state.

Reset
REQ-026 On reset=1, immediately and without waiting for clk, the block SHALL set digit0=0, digit1=0, pcnt=0, tick=0 and wrap=0.
REQ-027 Reset asserted mid-count or during load SHALL discard the pending step or load.
REQ-028 The first step after reset release SHALL occur TICK_DIV cycles after release with en held at 1.

Structure
REQ-029 A shared package bcd_pkg SHALL hold typedef bcd_t (4-bit logic) and constants BCD_MAX=9 and BCD_MIN=0.
REQ-030 One sub-module, bcd_digit, SHALL implement a single decade cell with ports step_in, up, load, load_digit and digit, plus a step_out carry/borrow; it SHALL be instantiated twice and chained units->tens.
REQ-031 The prescaler, tick register and wrap register SHALL reside in bcd_counter2.

Verification (TICK_DIV=4 for simulation)
REQ-032 Bench SHALL cover: reset, then en=1, up=1 for 40 clk -> digits 00,01,...,10; tick every 4th cycle; wrap never asserted.
REQ-033 Bench SHALL cover: load 0x98, up=1, en=1 -> after 2 ticks digits 00 and wrap=1 on the second tick only.
REQ-034 Bench SHALL cover: load 0x00, up=0 -> first tick gives digits 99 with wrap=1; next tick gives 98 with wrap=0.
REQ-035 Bench SHALL cover: load 0xA7 -> digit1=0, digit0=7; load 0x3F -> digit1=3, digit0=0.
REQ-036 Bench SHALL cover: en dropped for 10 clk at pcnt=2 -> digits and tick frozen; step occurs 2 cycles after en returns.
REQ-037 Bench SHALL cover: reset asserted between edges while digits=57 -> all outputs 0 before the next clk edge; load on the same cycle as a step -> load value wins, tick=0.
